// File: rtl/net_stream_pkg.sv
// Shared types and defaults for the network streaming blocks.
package net_stream_pkg;
   localparam int T_DEF = 16;
   localparam int N_DEF = 4;

   typedef logic signed [T_DEF-1:0] word_t;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;
endpackage

// File: rtl/vec_stream_tx_if.sv
// Vector-in / word-stream-out handshake bundle for vec_stream_tx.
interface vec_stream_tx_if #(
   parameter int T = 16,
   parameter int N = 4
);
   logic                vec_valid;
   logic                vec_ready;
   logic [N*T-1:0]      vec_data;
   logic                output_valid;
   logic                output_ready;
   logic signed [T-1:0] output_data;

   modport master (
      output vec_valid, vec_data, output_ready,
      input  vec_ready, output_valid, output_data
   );

   modport slave (
      input  vec_valid, vec_data, output_ready,
      output vec_ready, output_valid, output_data
   );
endinterface

// File: rtl/vec_stream_tx_buf.sv
// One N-word buffer entry: parallel load, word-select read, EMPTY/FULL flag.
module vec_stream_tx_buf import net_stream_pkg::*; #(
   parameter int T  = T_DEF,
   parameter int N  = N_DEF,
   parameter int CW = $clog2(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                clr_i,
   input  logic [N*T-1:0]      data_i,
   input  logic [CW-1:0]       sel_i,
   output logic signed [T-1:0] word_o,
   output buf_state_t          state_o
);
   logic [N*T-1:0] data_q, data_d;
   buf_state_t     state_q, state_d;

   // Load and clear never target the same entry in one cycle; load wins if they did.
   always_comb begin
      data_d  = data_q;
      state_d = state_q;
      if (clr_i) state_d = EMPTY;
      if (load_i) begin
         data_d  = data_i;
         state_d = FULL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         state_q <= EMPTY;
      end else begin
         data_q  <= data_d;
         state_q <= state_d;
      end
   end

   assign word_o  = data_q[sel_i*T +: T];
   assign state_o = state_q;
endmodule

// File: rtl/vec_stream_tx.sv
// Ping-pong vector-to-stream transmitter: vectors in, words out word 0 first.
// vec_ready depends only on registered state, never on output_ready.
module vec_stream_tx import net_stream_pkg::*; #(
   parameter int T = T_DEF,
   parameter int N = N_DEF
) (
   input  logic            clk,
   input  logic            reset,
   vec_stream_tx_if.slave  bus
);
   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       word_cnt_q, word_cnt_d;
   logic [1:0]          load, clr;
   buf_state_t          st [2];
   logic signed [T-1:0] wd [2];
   logic                vec_rdy, out_vld, accept, xfer, last_word;

   for (genvar i = 0; i < 2; i++) begin : g_buf
      vec_stream_tx_buf #(.T(T), .N(N), .CW(CW)) u_buf (
         .clk     (clk),
         .reset   (reset),
         .load_i  (load[i]),
         .clr_i   (clr[i]),
         .data_i  (bus.vec_data),
         .sel_i   (word_cnt_q),
         .word_o  (wd[i]),
         .state_o (st[i])
      );
   end

   assign vec_rdy   = (st[wr_ptr_q] == EMPTY) && reset;
   assign out_vld   = (st[rd_ptr_q] == FULL);
   assign accept    = bus.vec_valid && vec_rdy;
   assign xfer      = out_vld && bus.output_ready;
   assign last_word = (word_cnt_q == LAST);

   assign load = !accept ? 2'b00 : (wr_ptr_q ? 2'b10 : 2'b01);
   assign clr  = !(xfer && last_word) ? 2'b00 : (rd_ptr_q ? 2'b10 : 2'b01);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      word_cnt_d = word_cnt_q;
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (xfer) begin
         if (last_word) begin
            word_cnt_d = '0;
            rd_ptr_d   = ~rd_ptr_q;
         end else begin
            word_cnt_d = word_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign bus.vec_ready    = vec_rdy;
   assign bus.output_valid = out_vld;
   assign bus.output_data  = wd[rd_ptr_q];
endmodule

// File: doc/vec_stream_tx.md
# vec_stream_tx

Vector-to-stream transmitter feeding a layered network's serial `input_valid`/`input_ready`/`input_data` port. Accepts a whole input vector of `N` signed words in one parallel handshake. Holds it in a two-entry ping-pong buffer and emits it word by word, word 0 first, on a valid/ready stream. The block is the sending end of the streaming protocol the network's layers consume. It sits between the host/test harness and the network's input port.

## Interface
Parameters:
- `T`, 16: word width in bits, signed two's complement.
- `N`, 4: words per vector. Must be ≥ 2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. Low clears all state immediately.
- `vec_valid`  in  1: producer presents a vector.
- `vec_ready`  out  1: a buffer entry is free.
- `vec_data`  in  N*T: vector; word i at bits [i*T +: T], word 0 in the LSBs.
- `output_valid`  out  1: `output_data` holds a valid word.
- `output_ready`  in  1: downstream accepts a word.
- `output_data`  out  T (signed): current word.

## Operation
- Each of the two entries, A and B, is EMPTY or FULL and holds N words.
- `wr_ptr` (1 bit) selects the entry to fill; `rd_ptr` (1 bit) selects the entry being streamed.
- `word_cnt`, width $clog2(N), indexes the word currently presented.
- Load: when `vec_valid && vec_ready` at an edge, copy `vec_data` into entry `wr_ptr`, mark it FULL and toggle `wr_ptr`.
- `vec_ready` = (entry `wr_ptr` EMPTY) && `reset` high. It depends on registered state only, with no combinational path from `output_ready`.
- Stream:
  - `output_valid` = entry `rd_ptr` FULL.
  - `output_data` = word `word_cnt` of entry `rd_ptr`, a combinational mux from registers.
- Transfer: when `output_valid && output_ready` at an edge:
  - If `word_cnt` < N-1, increment `word_cnt`.
  - If `word_cnt` = N-1, reset `word_cnt` to 0, mark entry `rd_ptr` EMPTY and toggle `rd_ptr`.
- Simultaneous load and final-word transfer in the same cycle: both happen.
  - If they target different entries, no conflict.
  - If both entries were FULL, `vec_ready` was 0, so no load occurs. The freed entry is offered from the next cycle.
- While `output_valid`=1 and `output_ready`=0, `output_data` and `word_cnt` hold stable. This is the protocol stability rule.
- `vec_data` is sampled only on a load edge. Its value at other times is ignored.
- Reset values:
  - Both entries EMPTY with contents cleared to 0.
  - `wr_ptr` = `rd_ptr` = 0, `word_cnt` = 0.
  - `output_valid` = 0, `output_data` = 0.
  - `vec_ready` = 0 while `reset` is low, 1 in the first cycle after release.
- Reset mid-stream discards buffered and partially sent vectors. The next accepted vector starts at word 0.

## Timing
- Latency: a vector loaded at edge k gives `output_valid`=1 with word 0 during cycle k+1, provided the stream was idle.
- Throughput: one word per cycle under `output_ready`=1. Back-to-back vectors stream with zero bubbles when the producer keeps `vec_valid` high.
- With both entries FULL, `vec_ready`=0 until the edge that transfers the last word of entry `rd_ptr`.
- Capacity: up to 2 vectors buffered plus none in flight, i.e. 2N words total.

## Structure
- Shared package `net_stream_pkg`:
  - `localparam` defaults `T_DEF`=16 and `N_DEF`=4.
  - `typedef logic signed [T-1:0] word_t` for the default width.
  - `typedef enum logic {EMPTY, FULL} buf_state_t`.
- One sub-module, `vec_stream_tx_buf`: a single N×T entry with load enable, word-select read and an EMPTY/FULL flag. It is instantiated twice.
- Top-level `vec_stream_tx` holds `wr_ptr`, `rd_ptr`, `word_cnt` and the output mux.

## Test plan
- Single vector: load {0x7FFF, 0xFFFF, 0x0002, 0x0001} (word 0 = 0x0001) with `output_ready`=1. Output is 0x0001, 0x0002, 0xFFFF, 0x7FFF on 4 consecutive cycles starting 1 cycle after the load edge, then `output_valid`=0.
- Back-to-back: 3 vectors offered continuously, `output_ready`=1. Gives 12 words with no bubble. `vec_ready` deasserts only while both entries are FULL.
- Backpressure: `output_ready`=0 for 5 cycles mid-vector at word 2. `output_data`=0xFFFF held stable, `word_cnt` unchanged, no word lost or duplicated.
- Full buffer: load 2 vectors with `output_ready`=0. `vec_ready`=0 and a third `vec_valid` is not accepted. Releasing `output_ready` raises `vec_ready` the cycle after word 3 of the first vector transfers.
- Reset mid-operation: assert `reset` low after word 1 of a vector is sent. `output_valid` and `output_data` go to 0 immediately and `vec_ready`=0 during reset. After release, a new vector {4,3,2,1} streams 1,2,3,4 from word 0.
- Random: random `vec_valid`/`output_ready` over 1000 vectors. A scoreboard checks in-order, lossless delivery and the stability rule.
